qspi_ram_sysclk: RTL
====================

# qspi_ram_sysclk

Oversampled SPI/QSPI RAM peripheral, clocked entirely from the system clock. It is the parametrised successor to the spi_clk-clocked RAM peripheral. It synchronises the external SPI pins into `clk` and decodes single and quad read/write commands with configurable dummy cycles. It serves a parametrised byte RAM with wrap-around addressing and byte-granular write commit, and exposes a synchronous debug read port in the same clock domain.

## Interface
Parameters:
- `RAM_LEN_BITS`, 6: RAM holds 2^RAM_LEN_BITS bytes; address wraps modulo this size.
- `FAST_READ_DELAY`, 2: dummy SPI clocks for 6Bh, legal range 0..15.
- `FAST_DUMMY_1BIT`, 8: dummy SPI clocks for 0Bh, legal range 0..15.

Ports:
- `clk` input 1: system clock, the only clock.
- `rst_n` input 1: asynchronous active-low reset.
- `spi_clk` input 1: SPI clock, mode 0, asynchronous to `clk`.
- `spi_select` input 1: chip select, active low.
- `spi_d_in` input 4: D3..D0; D0 is MOSI.
- `spi_d_out` output 4: D3..D0; D1 is MISO in single mode.
- `spi_d_oe` output 4: per-pin output enable.
- `debug_addr` input RAM_LEN_BITS: debug read address.
- `debug_data` output 8: registered RAM byte at `debug_addr`.

## Operation
- Synchronisers: `spi_clk`, `spi_select` and `spi_d_in` each pass through 2 flops. Edges of `spi_clk` are detected from the synchronised value against its previous value.
- SPI rise (sclk_rise): samples input. SPI fall (sclk_fall): updates output.
- FSM states: IDLE, CMD, ADDR, DUMMY, READ, WRITE, BAD.
- IDLE -> CMD when synchronised select is low.
- CMD: 8 bits are shifted in on D0, MSB first.
  - 03h -> ADDR, then READ.
  - 0Bh -> ADDR, then DUMMY (FAST_DUMMY_1BIT), then READ.
  - 6Bh -> ADDR, then DUMMY (FAST_READ_DELAY), then quad READ.
  - 02h -> ADDR, then WRITE.
  - 32h -> ADDR, then quad WRITE.
  - Any other value -> BAD. BAD ignores all traffic until deselect.
- ADDR: 24 bits on D0, MSB first. Only the low RAM_LEN_BITS bits are kept.
- DUMMY: counts sclk_rise events. With a count of 0, DUMMY is skipped.
- READ, single mode:
  - One bit per sclk_fall on D1, MSB first; `spi_d_oe`=0010.
  - After 8 bits, address increments.
- READ, quad mode:
  - One nibble per sclk_fall on D3..D0, high nibble first; `spi_d_oe`=1111.
  - After 2 nibbles, address increments.
- WRITE: bits (single) or nibbles (quad) are assembled into a byte register.
  - When the byte is complete, it is written to RAM and the address increments.
  - A partial byte at deselect is discarded.
- Address increment wraps from 2^RAM_LEN_BITS-1 to 0.
- Deselect: when synchronised `spi_select` rises, any state goes to IDLE on the next `clk`. Deselect clears `spi_d_oe` to 0000, the bit/nibble counters and the partial byte. RAM is untouched.
- Debug port: `debug_data` <= RAM[`debug_addr`] every `clk`.
  - If an SPI write to the same address commits in the same cycle, `debug_data` shows the old value, and the new value appears one cycle later.

## Timing
- Reset (`rst_n`=0): FSM=IDLE, `spi_d_out`=0000, `spi_d_oe`=0000, `debug_data`=00h; synchronisers, counters, address and byte register = 0. RAM is not reset.
- Reset mid-transaction aborts it. Any incomplete byte is lost.
- Input latency: a pin change is seen 2 `clk` after capture. sclk_rise/sclk_fall pulse for 1 `clk`, 3 `clk` after the pin edge.
- Output latency: `spi_d_out` updates on the `clk` after the sclk_fall pulse, i.e. 4 `clk` after the pin falling edge.
- Output enable: `spi_d_oe` asserts in the same cycle as the first data output, i.e. on the sclk_fall following the last address or dummy sclk_rise.
- Guaranteed operation requires spi_clk ≤ clk/10 at 50% duty, and `spi_select` setup/hold ≥ 3 `clk` around the first/last spi_clk edge.
- Write commit: RAM is written on the `clk` after the sclk_rise pulse carrying the final bit/nibble.
- Read data for the next byte is fetched at the increment, so back-to-back bytes have no gap.

## Test plan
- Reset: assert `rst_n`=0 mid-read -> `spi_d_oe`=0000, `spi_d_out`=0000, `debug_data`=00h. After release, a new 03h transaction works.
- Single write then read: 02h 000000h A5h 3Ch, then 03h 000000h -> MISO returns A5h then 3Ch. `debug_addr`=1 gives 3Ch.
- Quad write then quad read: 32h 000010h with nibbles 1,2,3,4, then 6Bh 000010h with 2 dummy clocks -> D3..D0 returns 1,2,3,4 with `spi_d_oe`=1111.
- Wrap-around: RAM_LEN_BITS=6, 02h 00003Fh 11h 22h -> RAM[3Fh]=11h, RAM[00h]=22h. A 0Bh read at 3Fh returns 11h then 22h after 8 dummy clocks.
- Partial byte and bad command: 02h 000005h, 5 bits, deselect -> RAM[05h] unchanged. Command 9Fh -> `spi_d_oe` stays 0000 and RAM is unchanged.
- Debug collision: SPI write 77h committing to address 4 while `debug_addr`=4 -> old value on the commit cycle, 77h one cycle later.

Source files
------------

// File: rtl/qspi_ram_sysclk_if.sv
// qspi_ram_sysclk_if: pin and debug bundle for the system-clock QSPI RAM.
// Signals:
//   spi_clk, spi_select, spi_d_in[3:0]  host -> peripheral SPI pins
//   spi_d_out[3:0], spi_d_oe[3:0]       peripheral -> host data and per-pin enable
//   debug_addr                          debug read address
//   debug_data[7:0]                     registered RAM byte at debug_addr
// Modports: master (host/bench side), slave (peripheral side).
interface qspi_ram_sysclk_if #(
  parameter int RAM_LEN_BITS = 6
);
  logic                    spi_clk;
  logic                    spi_select;
  logic [3:0]              spi_d_in;
  logic [3:0]              spi_d_out;
  logic [3:0]              spi_d_oe;
  logic [RAM_LEN_BITS-1:0] debug_addr;
  logic [7:0]              debug_data;

  modport master (
    output spi_clk, spi_select, spi_d_in, debug_addr,
    input  spi_d_out, spi_d_oe, debug_data
  );

  modport slave (
    input  spi_clk, spi_select, spi_d_in, debug_addr,
    output spi_d_out, spi_d_oe, debug_data
  );
endinterface

// File: rtl/qspi_ram_sysclk.sv
// qspi_ram_sysclk: oversampled SPI/QSPI byte-RAM peripheral clocked only by clk.
// The SPI pins are synchronised into clk, spi_clk edges are detected there, and
// single/quad read and write commands are decoded against a 2^RAM_LEN_BITS byte RAM.
// Ports:
//   clk    system clock (the only clock)
//   rst_n  asynchronous active-low reset
//   bus    slave modport: SPI pins (spi_clk, spi_select, spi_d_in -> spi_d_out,
//          spi_d_oe) and the debug read port (debug_addr -> debug_data, registered)
//
// state | meaning
// IDLE  | deselected, waiting for synchronised select low
// CMD   | shifting 8 command bits in on D0
// ADDR  | shifting 24 address bits in on D0, low RAM_LEN_BITS kept
// DUMMY | counting dummy sclk rises before read data
// READ  | driving bits (D1) or nibbles (D3..D0) on sclk fall
// WRITE | assembling bytes on sclk rise, committing each full byte
// BAD   | unknown command, ignore traffic until deselect
module qspi_ram_sysclk #(
  parameter int RAM_LEN_BITS    = 6,
  parameter int FAST_READ_DELAY = 2,
  parameter int FAST_DUMMY_1BIT = 8
) (
  input logic              clk,
  input logic              rst_n,
  qspi_ram_sysclk_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_READ, ST_WRITE, ST_BAD
  } state_t;

  localparam int RAM_BYTES = 1 << RAM_LEN_BITS;
  localparam logic [3:0] DLY_QUAD   = 4'(FAST_READ_DELAY);
  localparam logic [3:0] DLY_SINGLE = 4'(FAST_DUMMY_1BIT);
  localparam logic [RAM_LEN_BITS-1:0] ADDR_ONE = RAM_LEN_BITS'(1);

  logic       sclk_s1, sclk_s2, sclk_prev;
  logic       sel_s1, sel_s2;
  logic [3:0] din_s1, din_s2;
  logic       sclk_rise, sclk_fall;

  state_t                  state;
  logic [4:0]              cnt;
  logic [7:0]              shreg;
  logic [RAM_LEN_BITS-1:0] addr;
  logic                    quad;
  logic                    wr_mode;
  logic [3:0]              dly;
  logic [3:0]              d_out;
  logic [3:0]              d_oe;

  logic [7:0]              ram [RAM_BYTES];
  logic                    ram_we;
  logic [RAM_LEN_BITS-1:0] ram_waddr;
  logic [7:0]              ram_wdata;
  logic [7:0]              dbg_q;

  logic [7:0]              bit_next;
  logic [7:0]              wr_byte;
  logic [RAM_LEN_BITS-1:0] addr_next;
  logic [RAM_LEN_BITS-1:0] addr_inc;
  logic                    unit_last;

  assign sclk_rise = sclk_s2 & ~sclk_prev;
  assign sclk_fall = ~sclk_s2 & sclk_prev;
  assign bit_next  = {shreg[6:0], din_s2[0]};
  assign wr_byte   = quad ? {shreg[3:0], din_s2} : bit_next;
  // Only the low address bits are kept; the upper 24-bit address bits fall off the top.
  assign addr_next = {addr[RAM_LEN_BITS-2:0], din_s2[0]};
  assign addr_inc  = addr + ADDR_ONE;
  // A byte is 2 nibbles in quad mode, 8 bits in single mode.
  assign unit_last = quad ? (cnt == 5'd1) : (cnt == 5'd7);

  assign bus.spi_d_out  = d_out;
  assign bus.spi_d_oe   = d_oe;
  assign bus.debug_data = dbg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      sel_s1    <= 1'b0;
      sel_s2    <= 1'b0;
      din_s1    <= '0;
      din_s2    <= '0;
    end else begin
      sclk_s1   <= bus.spi_clk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      sel_s1    <= bus.spi_select;
      sel_s2    <= sel_s1;
      din_s1    <= bus.spi_d_in;
      din_s2    <= din_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      addr      <= '0;
      quad      <= 1'b0;
      wr_mode   <= 1'b0;
      dly       <= '0;
      d_out     <= '0;
      d_oe      <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      if (sel_s2) begin
        // Deselect drops any partial byte; RAM and address are left alone.
        state <= ST_IDLE;
        cnt   <= '0;
        shreg <= '0;
        d_oe  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_CMD;
            cnt   <= '0;
            shreg <= '0;
          end
          ST_CMD: if (sclk_rise) begin
            if (cnt == 5'd7) begin
              cnt     <= '0;
              shreg   <= '0;
              state   <= ST_ADDR;
              quad    <= 1'b0;
              wr_mode <= 1'b0;
              dly     <= '0;
              case (bit_next)
                8'h03: ;
                8'h0B: dly <= DLY_SINGLE;
                8'h6B: begin quad <= 1'b1; dly <= DLY_QUAD; end
                8'h02: wr_mode <= 1'b1;
                8'h32: begin wr_mode <= 1'b1; quad <= 1'b1; end
                default: state <= ST_BAD;
              endcase
            end else begin
              cnt   <= cnt + 5'd1;
              shreg <= bit_next;
            end
          end
          ST_ADDR: if (sclk_rise) begin
            addr <= addr_next;
            if (cnt == 5'd23) begin
              cnt <= '0;
              if (wr_mode) begin
                state <= ST_WRITE;
                shreg <= '0;
              end else if (dly == 4'd0) begin
                state <= ST_READ;
                shreg <= ram[addr_next];
              end else begin
                state <= ST_DUMMY;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          ST_DUMMY: if (sclk_rise) begin
            if ((cnt + 5'd1) == {1'b0, dly}) begin
              cnt   <= '0;
              state <= ST_READ;
              shreg <= ram[addr];
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          ST_READ: if (sclk_fall) begin
            d_oe  <= quad ? 4'b1111 : 4'b0010;
            d_out <= quad ? shreg[7:4] : {2'b00, shreg[7], 1'b0};
            if (unit_last) begin
              // Prefetch the following byte so consecutive bytes stream without a gap.
              cnt   <= '0;
              addr  <= addr_inc;
              shreg <= ram[addr_inc];
            end else begin
              cnt   <= cnt + 5'd1;
              shreg <= quad ? {shreg[3:0], 4'b0000} : {shreg[6:0], 1'b0};
            end
          end
          ST_WRITE: if (sclk_rise) begin
            if (unit_last) begin
              ram_we    <= 1'b1;
              ram_waddr <= addr;
              ram_wdata <= wr_byte;
              addr      <= addr_inc;
              cnt       <= '0;
              shreg     <= '0;
            end else begin
              cnt   <= cnt + 5'd1;
              shreg <= wr_byte;
            end
          end
          ST_BAD: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // RAM contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Reads the pre-write value when a commit lands on the same address this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_q <= '0;
    else        dbg_q <= ram[bus.debug_addr];
  end

endmodule
